// File: rtl/flag_unit_arbiter.sv
// Round-robin arbiter sharing one add/subtract + NZCV flag unit between the
// execute stage (port 0) and the compare/branch unit (port 1).
module flag_unit_arbiter #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_op1,
   input  logic [W-1:0] req0_op2,
   input  logic         req0_sub,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_op1,
   input  logic [W-1:0] req1_op2,
   input  logic         req1_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_result,
   output logic [3:0]   out_flags,
   output logic         out_id,
   output logic [3:0]   flag_q
);

   // state | meaning
   // IDLE  | waiting for a request; grants one port per visit
   // CALC  | latched operands go through the adder, result/flags registered
   // HOLD  | result presented until the consumer takes it

   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

   state_t       state;
   logic         last_grant;
   logic [W-1:0] op1_q;
   logic [W-1:0] op2_q;
   logic         sub_q;
   logic         id_q;
   logic         grant0;
   logic         grant1;
   logic [W-1:0] b;
   logic [W:0]   sum;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst && state == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Subtraction is op1 + ~op2 + 1, so C = 1 means no borrow.
   assign b   = sub_q ? ~op2_q : op2_q;
   assign sum = {1'b0, op1_q} + {1'b0, b} + {{W{1'b0}}, sub_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op1_q      <= '0;
         op2_q      <= '0;
         sub_q      <= 1'b0;
         id_q       <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
         out_id     <= 1'b0;
         flag_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op1_q <= grant1 ? req1_op1 : req0_op1;
                  op2_q <= grant1 ? req1_op2 : req0_op2;
                  sub_q <= grant1 ? req1_sub : req0_sub;
                  id_q  <= grant1;
                  state <= CALC;
               end
            end
            CALC: begin
               out_result <= sum[W-1:0];
               out_flags  <= {sum[W-1],
                              sum[W-1:0] == '0,
                              sum[W],
                              (op1_q[W-1] == b[W-1]) && (sum[W-1] != op1_q[W-1])};
               out_id     <= id_q;
               out_valid  <= 1'b1;
               state      <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  flag_q     <= out_flags;
                  last_grant <= out_id;
                  out_valid  <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flag_unit_arbiter.sv
// Self-checking bench for flag_unit_arbiter: directed vectors plus randomized
// operations checked against an integer-arithmetic reference model.
module tb_flag_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sub;
   logic [16:0] req0_op1, req0_op2;
   logic        req1_valid, req1_ready, req1_sub;
   logic [16:0] req1_op1, req1_op2;
   logic        out_valid, out_ready, out_id;
   logic [16:0] out_result;
   logic [3:0]  out_flags, flag_q;

   int   checks   = 0;
   int   failures = 0;
   logic [3:0] m_flag;
   logic       m_last;

   flag_unit_arbiter #(.W(17)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sub(req1_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags),
      .out_id(out_id), .flag_q(flag_q)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // {N,Z,C,V,result} from plain unsigned/signed integer arithmetic.
   function automatic logic [20:0] model(input logic [16:0] a, input logic [16:0] bb,
                                         input logic sub);
      int ua, ub, s, sa, sb, ss;
      logic [16:0] r;
      logic n, z, c, v;
      ua = int'(a);
      ub = int'(bb);
      s  = sub ? ua - ub : ua + ub;
      r  = s[16:0];
      c  = sub ? (ua >= ub) : (s >= 131072);
      sa = a[16]  ? ua - 131072 : ua;
      sb = bb[16] ? ub - 131072 : ub;
      ss = sub ? sa - sb : sa + sb;
      v  = (ss > 65535) || (ss < -65536);
      n  = r[16];
      z  = (r == 17'd0);
      return {n, z, c, v, r};
   endfunction

   function automatic logic [16:0] pick_op();
      case ($urandom_range(0, 5))
         0: return 17'h1FFFF;
         1: return 17'h10000;
         2: return 17'h0FFFF;
         3: return 17'h00000;
         default: return 17'($urandom);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      m_flag = 4'b0000;
      m_last = 1'b1;
   endtask

   // One lone request on 'port' with out_ready held low for 'stall' HOLD cycles.
   task automatic run_op(input int port, input logic [16:0] a, input logic [16:0] bb,
                         input logic sub, input int stall);
      logic [20:0] e;
      e = model(a, bb, sub);
      if (port == 0) begin
         req0_valid = 1'b1; req0_op1 = a; req0_op2 = bb; req0_sub = sub;
      end else begin
         req1_valid = 1'b1; req1_op1 = a; req1_op2 = bb; req1_sub = sub;
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (req0_ready !== (port == 0) || req1_ready !== (port == 1)) begin
         failures++;
         $display("FAIL accept_ready port=%0d got r0=%b r1=%b", port, req0_ready, req1_ready);
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op1 = 17'($urandom); req1_op1 = 17'($urandom);
      #1;
      checks++;
      if (out_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || flag_q !== m_flag) begin
         failures++;
         $display("FAIL calc_cycle got ov=%b r0=%b r1=%b fq=%b want ov=0 r=00 fq=%b",
                  out_valid, req0_ready, req1_ready, flag_q, m_flag);
      end
      step();
      out_ready = (stall == 0);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== e[16:0] || out_flags !== e[20:17] ||
          out_id !== port[0]) begin
         failures++;
         $display("FAIL result a=%h b=%h sub=%b got ov=%b res=%h fl=%b id=%b want ov=1 res=%h fl=%b id=%0d",
                  a, bb, sub, out_valid, out_result, out_flags, out_id, e[16:0], e[20:17], port);
      end
      for (int k = 0; k < stall; k++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         #1;
         checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || flag_q !== m_flag ||
             out_valid !== 1'b1 || out_result !== e[16:0] || out_flags !== e[20:17] ||
             out_id !== port[0]) begin
            failures++;
            $display("FAIL hold_stall k=%0d got r0=%b r1=%b fq=%b ov=%b res=%h fl=%b want r=00 fq=%b ov=1 res=%h fl=%b",
                     k, req0_ready, req1_ready, flag_q, out_valid, out_result, out_flags,
                     m_flag, e[16:0], e[20:17]);
         end
         step();
         req0_valid = 1'b0; req1_valid = 1'b0;
         if (k == stall - 1) out_ready = 1'b1;
      end
      step();
      checks++;
      if (flag_q !== e[20:17] || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flag_update got fq=%b ov=%b want fq=%b ov=0", flag_q, out_valid, e[20:17]);
      end
      m_flag = e[20:17];
      m_last = port[0];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
      req0_op1 = 17'd1; req0_op2 = 17'd1; req0_sub = 1'b0;
      req1_op1 = 17'd1; req1_op2 = 17'd1; req1_sub = 1'b0;
      step();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b0 ||
          out_result !== 17'd0 || out_flags !== 4'd0 || out_id !== 1'b0 || flag_q !== 4'd0) begin
         failures++;
         $display("FAIL reset_state got r0=%b r1=%b ov=%b res=%h fl=%b id=%b fq=%b want all zero",
                  req0_ready, req1_ready, out_valid, out_result, out_flags, out_id, flag_q);
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      m_flag = 4'b0000;
      m_last = 1'b1;
   endtask

   task automatic test_plan_vectors();
      run_op(0, 17'd5, 17'd3, 1'b0, 0);
      run_op(1, 17'h00ABC, 17'h00ABC, 1'b1, 0);
      run_op(0, 17'h0FFFF, 17'd1, 1'b0, 1);
      run_op(1, 17'h1FFFF, 17'd1, 1'b0, 0);
      run_op(0, 17'd3, 17'd5, 1'b1, 0);
   endtask

   task automatic test_backpressure();
      run_op(1, 17'h10000, 17'h00001, 1'b1, 4);
      run_op(0, 17'($urandom), 17'($urandom), 1'b0, 4);
   endtask

   task automatic test_random_single();
      for (int i = 0; i < 24; i++)
         run_op(int'($urandom_range(0, 1)), pick_op(), pick_op(), 1'($urandom),
                int'($urandom_range(0, 3)));
   endtask

   task automatic test_reset_mid();
      logic [20:0] e;
      run_op(0, 17'd5, 17'd5, 1'b1, 0);
      req1_valid = 1'b1; req1_op1 = 17'd7; req1_op2 = 17'd9; req1_sub = 1'b1;
      #1;
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_accept got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready);
      end
      step();
      req1_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || flag_q !== 4'd0 || out_result !== 17'd0 || out_flags !== 4'd0) begin
         failures++;
         $display("FAIL mid_reset got ov=%b fq=%b res=%h fl=%b want zeros",
                  out_valid, flag_q, out_result, out_flags);
      end
      m_flag = 4'b0000;
      m_last = 1'b1;
      req0_valid = 1'b1; req0_op1 = 17'h1FFFF; req0_op2 = 17'h1FFFF; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_op1 = 17'd2; req1_op2 = 17'd1; req1_sub = 1'b0;
      out_ready = 1'b1;
      e = model(17'h1FFFF, 17'h1FFFF, 1'b0);
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_grant got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      step();
      checks++;
      if (flag_q !== e[20:17]) begin
         failures++;
         $display("FAIL post_reset_flags got fq=%b want %b", flag_q, e[20:17]);
      end
      m_flag = e[20:17];
      m_last = 1'b0;
   endtask

   task automatic test_contention();
      logic [20:0] e;
      logic        g;
      apply_reset();
      req0_op1 = pick_op(); req0_op2 = pick_op(); req0_sub = 1'($urandom);
      req1_op1 = pick_op(); req1_op2 = pick_op(); req1_sub = 1'($urandom);
      req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         g = !m_last;
         e = g ? model(req1_op1, req1_op2, req1_sub) : model(req0_op1, req0_op2, req0_sub);
         #1;
         checks++;
         if (req0_ready !== !g || req1_ready !== g) begin
            failures++;
            $display("FAIL contention_grant i=%0d got r0=%b r1=%b want port %0d", i,
                     req0_ready, req1_ready, g);
         end
         step();
         if (g) begin
            req1_op1 = pick_op(); req1_op2 = pick_op(); req1_sub = 1'($urandom);
         end else begin
            req0_op1 = pick_op(); req0_op2 = pick_op(); req0_sub = 1'($urandom);
         end
         #1;
         checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL contention_calc i=%0d got r0=%b r1=%b ov=%b want 0 0 0", i,
                     req0_ready, req1_ready, out_valid);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_id !== g || out_result !== e[16:0] ||
             out_flags !== e[20:17] || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL contention_out i=%0d got ov=%b id=%b res=%h fl=%b want ov=1 id=%b res=%h fl=%b",
                     i, out_valid, out_id, out_result, out_flags, g, e[16:0], e[20:17]);
         end
         step();
         checks++;
         if (flag_q !== e[20:17]) begin
            failures++;
            $display("FAIL contention_flags i=%0d got fq=%b want %b", i, flag_q, e[20:17]);
         end
         m_flag = e[20:17];
         m_last = g;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
      req0_op1 = '0; req0_op2 = '0; req0_sub = 1'b0;
      req1_op1 = '0; req1_op2 = '0; req1_sub = 1'b0;
      m_flag = 4'b0000;
      m_last = 1'b1;
      step();
      test_reset();
      test_plan_vectors();
      test_backpressure();
      test_random_single();
      test_reset_mid();
      test_contention();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
